// File: rtl/seq_calc_pkg.sv
// Shared types and helpers for the sequential calculator.
// Saturation is selected in the top module by SEQ_CALC_SAT_EN.
package seq_calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_POW = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    function automatic logic [63:0] smax(int nb);
        return (64'd1 << (nb - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] smin(int nb);
        return ~smax(nb);
    endfunction

endpackage

// File: rtl/seq_calc_div.sv
// Unsigned restoring divider, one quotient bit per cycle.
// The first bit is produced on the start edge, so done follows NB-1 cycles later.
module seq_calc_div #(
    parameter int NB = 48
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NB-1:0] dividend,
    input  logic [NB-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [NB-1:0] quotient
);
    localparam int CW = $clog2(NB);

    logic [NB-1:0] rem_q, quo_q, dvs_q;
    logic [NB-1:0] rem_d, quo_d;
    logic [NB-1:0] r_in, q_in, d_in;
    logic [NB:0]   sh, dif;
    logic          ge;
    logic [CW-1:0] cnt_q;
    logic          busy_q, done_q;

    always_comb begin
        r_in  = start ? '0 : rem_q;
        q_in  = start ? dividend : quo_q;
        d_in  = start ? divisor : dvs_q;
        sh    = {r_in, q_in[NB-1]};
        dif   = sh - {1'b0, d_in};
        ge    = sh >= {1'b0, d_in};
        rem_d = ge ? dif[NB-1:0] : sh[NB-1:0];
        quo_d = {q_in[NB-2:0], ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                dvs_q  <= d_in;
                cnt_q  <= CW'(NB - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/seq_calculator.sv
// Multi-cycle signed add/sub/mul/div/pow with valid/ready on both sides.
// Define SEQ_CALC_SAT_EN to saturate overflowed results instead of wrapping.
module seq_calculator
    import seq_calc_pkg::*;
#(
    parameter int NB  = 48,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [NB-1:0]  a,
    input  logic [NB-1:0]  b,
    input  logic [OPW-1:0] operand,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [NB-1:0]  result,
    output logic           ovf,
    output logic           err
);
`ifdef SEQ_CALC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam logic [63:0]   MAX64 = smax(NB);
    localparam logic [63:0]   MIN64 = smin(NB);
    localparam logic [NB-1:0] MAXV  = MAX64[NB-1:0];
    localparam logic [NB-1:0] MINV  = MIN64[NB-1:0];

    function automatic logic [2*NB-1:0] smul(logic [NB-1:0] x, logic [NB-1:0] y);
        return $signed({{NB{x[NB-1]}}, x}) * $signed({{NB{y[NB-1]}}, y});
    endfunction

    function automatic logic povf(logic [2*NB-1:0] p);
        return !((&p[2*NB-1:NB-1]) || !(|p[2*NB-1:NB-1]));
    endfunction

    function automatic logic [NB-1:0] fin(logic [NB-1:0] w, logic o, logic neg);
        return (SAT_EN && o) ? (neg ? MINV : MAXV) : w;
    endfunction

    function automatic logic [NB-1:0] mag(logic [NB-1:0] x);
        return x[NB-1] ? -x : x;
    endfunction

    state_e          state_q, state_d;
    logic [NB-1:0]   res_q, res_d, acc_q, acc_d;
    logic [NB-1:0]   base_q, base_d, exp_q, exp_d;
    logic            ovf_q, ovf_d, err_q, err_d;
    logic            neg_q, neg_d, div_q, div_d;
    logic [NB-1:0]   sum, dif, acc_n, exp_n, qs;
    logic [2*NB-1:0] mul_p, acc_p, sq_p;
    logic            add_o, sub_o, ovf_n;
    logic            div_start, div_busy, div_done;
    logic [NB-1:0]   div_quo;

    seq_calc_div #(.NB(NB)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (mag(a)),
        .divisor  (mag(b)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_comb begin
        sum   = a + b;
        dif   = a - b;
        add_o = (a[NB-1] == b[NB-1]) && (sum[NB-1] != a[NB-1]);
        sub_o = (a[NB-1] != b[NB-1]) && (dif[NB-1] != a[NB-1]);
        mul_p = smul(a, b);
        acc_p = smul(acc_q, base_q);
        sq_p  = smul(base_q, base_q);
        acc_n = exp_q[0] ? acc_p[NB-1:0] : acc_q;
        exp_n = exp_q >> 1;
        ovf_n = ovf_q | (exp_q[0] & povf(acc_p))
              | ((exp_n != '0) & povf(sq_p));
        qs    = neg_q ? -div_quo : div_quo;
    end

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        acc_d     = acc_q;
        base_d    = base_q;
        exp_d     = exp_q;
        neg_d     = neg_q;
        div_d     = div_q;
        div_start = 1'b0;
        unique case (state_q)
            IDLE: if (in_valid) begin
                state_d = DONE;
                res_d   = '0;
                ovf_d   = 1'b0;
                err_d   = 1'b0;
                div_d   = 1'b0;
                case (operand)
                    OPW'(OP_ADD): begin
                        res_d = fin(sum, add_o, a[NB-1]);
                        ovf_d = add_o;
                    end
                    OPW'(OP_SUB): begin
                        res_d = fin(dif, sub_o, a[NB-1]);
                        ovf_d = sub_o;
                    end
                    OPW'(OP_MUL): begin
                        res_d = fin(mul_p[NB-1:0], povf(mul_p), mul_p[2*NB-1]);
                        ovf_d = povf(mul_p);
                    end
                    OPW'(OP_DIV): begin
                        if (b == '0) begin
                            err_d = 1'b1;
                        end else begin
                            div_start = 1'b1;
                            div_d     = 1'b1;
                            neg_d     = a[NB-1] ^ b[NB-1];
                            ovf_d     = (a == MINV) && (b == '1);
                            state_d   = BUSY;
                        end
                    end
                    OPW'(OP_POW): begin
                        if (b[NB-1]) begin
                            err_d = 1'b1;
                        end else if (b == '0) begin
                            res_d = NB'(1);
                        end else begin
                            acc_d   = NB'(1);
                            base_d  = a;
                            exp_d   = b;
                            neg_d   = a[NB-1] & b[0];
                            state_d = BUSY;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end
            BUSY: begin
                if (div_q) begin
                    if (div_done && !div_busy) begin
                        res_d   = fin(qs, ovf_q, 1'b0);
                        state_d = DONE;
                    end
                end else begin
                    acc_d  = acc_n;
                    base_d = sq_p[NB-1:0];
                    exp_d  = exp_n;
                    ovf_d  = ovf_n;
                    if (exp_n == '0) begin
                        res_d   = fin(acc_n, ovf_n, neg_q);
                        state_d = DONE;
                    end
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            base_q  <= '0;
            exp_q   <= '0;
            neg_q   <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            neg_q   <= neg_d;
            div_q   <= div_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign ovf       = ovf_q & ~err_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_calculator.sv
// Directed scoreboard bench for seq_calculator (NB=48).
// Expected values follow SEQ_CALC_SAT_EN when it is defined.
module tb_seq_calculator;
`ifdef SEQ_CALC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [47:0] MAX = 48'h7FFF_FFFF_FFFF;
    localparam logic [47:0] MIN = 48'h8000_0000_0000;
    localparam logic signed [127:0] WMAX = 128'sd140737488355327;
    localparam logic signed [127:0] WMIN = -128'sd140737488355328;

    typedef struct {
        logic [47:0] res;
        logic        ovf;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] a = '0;
    logic [47:0] b = '0;
    logic [2:0]  operand = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] result;
    logic        ovf, err;

    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];

    seq_calculator #(.NB(48), .OPW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .operand   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(logic [2:0] op, logic [47:0] x, logic [47:0] y);
        exp_t e;
        logic signed [127:0] sx, sy, t;
        sx = $signed(x);
        sy = $signed(y);
        t = 0;
        e.res = '0;
        e.ovf = 1'b0;
        e.err = 1'b0;
        e.lat = 1;
        case (op)
            3'd0: t = sx + sy;
            3'd1: t = sx - sy;
            3'd2: t = sx * sy;
            3'd3: begin
                if (sy == 0) e.err = 1'b1;
                else begin
                    t = sx / sy;
                    e.lat = 49;
                end
            end
            3'd4: begin
                if (sy < 0) e.err = 1'b1;
                else begin
                    t = 1;
                    for (int i = 0; i < int'(y); i++) t = t * sx;
                    for (int i = 0; i < 48; i++) if (y[i]) e.lat = i + 2;
                end
            end
            default: e.err = 1'b1;
        endcase
        if (!e.err) begin
            e.ovf = (t > WMAX) || (t < WMIN);
            e.res = t[47:0];
            if (SAT && e.ovf) e.res = (t < 0) ? MIN : MAX;
        end
        return e;
    endfunction

    // Caller is positioned at a negedge with the DUT idle.
    task automatic run(input string nm, input logic [2:0] op,
                       input logic [47:0] x, input logic [47:0] y, input int hold);
        exp_t e;
        int n, lat;
        logic [47:0] held;
        operand = op;
        a = x;
        b = y;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_accept_wait"}, n, 0);
        sbq.push_back(model(op, x, y));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        e = sbq.pop_front();
        chk({nm, "_latency"}, lat, e.lat);
        chk({nm, "_result"}, result, e.res);
        chk({nm, "_ovf"}, ovf, e.ovf);
        chk({nm, "_err"}, err, e.err);
        held = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = ~x;
            operand = 3'd0;
            @(negedge clk);
            chk({nm, "_hold_result"}, result, held);
            chk({nm, "_hold_valid"}, out_valid, 1);
            chk({nm, "_hold_in_ready"}, in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_drained"}, out_valid, 0);
        chk({nm, "_ready_after"}, in_ready, 1);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        run("add_big", 3'd0, 48'd999999999999, 48'd1, 0);
        run("add_max", 3'd0, MAX, 48'd1, 0);
        run("sub_min", 3'd1, MIN, 48'd1, 0);
        run("mul_neg", 3'd2, 48'd123456789, -48'sd987654, 0);
        run("mul_ovf", 3'd2, MAX, 48'd2, 0);
        run("pow_10_12", 3'd4, 48'd10, 48'd12, 0);
        run("pow_10_15", 3'd4, 48'd10, 48'd15, 0);
        run("pow_m2_47", 3'd4, -48'sd2, 48'd47, 0);
        run("pow_m3_31", 3'd4, -48'sd3, 48'd31, 0);
        run("pow_0_0", 3'd4, 48'd0, 48'd0, 0);
        run("pow_3_1", 3'd4, 48'd3, 48'd1, 0);
        run("div_m7_2", 3'd3, -48'sd7, 48'd2, 0);
        run("div_by0", 3'd3, 48'd5, 48'd0, 0);
        run("div_min", 3'd3, MIN, -48'sd1, 0);
        run("div_big", 3'd3, 48'd1000000000000, -48'sd12345, 0);
        run("bp_add", 3'd0, 48'd5, 48'd6, 5);
        run("bp_next", 3'd1, 48'd5, 48'd6, 0);

        operand = 3'd3;
        a = 48'd100;
        b = 48'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_div_busy", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        rst = 1'b0;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_rst_no_result", seen, 0);
        chk("mid_rst_ready", in_ready, 1);

        run("pow_neg_exp", 3'd4, -48'sd10, -48'sd1, 0);
        run("illegal_6", 3'd6, 48'd1, 48'd2, 0);
        run("illegal_7", 3'd7, MAX, MAX, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
